// File: rtl/mem_access_unit.sv
// MEM-stage data-bus master: turns the EX/MEM access into a req/ack transaction, stalls the pipe,
// and returns size-extended load data. Define MISALIGN_TRAP_EN to trap misaligned W/H accesses.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [2:0]  dmtype_in,
  input  logic        memwrite_in,
  input  logic        memread_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        bus_err_out
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_out,
  output logic [31:0] badaddr_out
`endif
);

  localparam logic [2:0] DmH  = 3'b001;
  localparam logic [2:0] DmHU = 3'b010;
  localparam logic [2:0] DmB  = 3'b011;
  localparam logic [2:0] DmBU = 3'b100;

  // Timeout fires in the TIMEOUT_CYCLES-th BUSY cycle, so BUSY never exceeds that many cycles.
  localparam logic       TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] CntLast   = 8'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  dmtype_q, dmtype_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        bus_err_q, bus_err_d;
  logic        stall;
  logic        access, in_byte, in_half, timeout;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
  logic [31:0] badaddr_q, badaddr_d;
  logic        misaligned;
`endif

  assign access  = memwrite_in | memread_in;
  assign in_byte = (dmtype_in == DmB) || (dmtype_in == DmBU);
  assign in_half = (dmtype_in == DmH) || (dmtype_in == DmHU);
  assign timeout = TimeoutEn && (cnt_q == CntLast);
`ifdef MISALIGN_TRAP_EN
  assign misaligned = in_half ? addr_in[0] : (!in_byte && (addr_in[1:0] != 2'b00));
`endif

  // Lane select and extension of the returned word for the latched access.
  always_comb begin
    lane_b = bus_rdata[7:0];
    unique case (off_q)
      2'd0: lane_b = bus_rdata[7:0];
      2'd1: lane_b = bus_rdata[15:8];
      2'd2: lane_b = bus_rdata[23:16];
      2'd3: lane_b = bus_rdata[31:24];
      default: lane_b = bus_rdata[7:0];
    endcase
    lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (dmtype_q)
      DmB:     load_ext = {{24{lane_b[7]}}, lane_b};
      DmBU:    load_ext = {24'h0, lane_b};
      DmH:     load_ext = {{16{lane_h[15]}}, lane_h};
      DmHU:    load_ext = {16'h0, lane_h};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    off_d       = off_q;
    dmtype_d    = dmtype_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    bus_err_d   = 1'b0;
    stall       = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign_d  = 1'b0;
    badaddr_d   = badaddr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (access) begin
          stall = 1'b1;
`ifdef MISALIGN_TRAP_EN
          if (misaligned) begin
            misalign_d = 1'b1;
            badaddr_d  = addr_in;
            state_d    = StDone;
          end else begin
`else
          begin
`endif
            we_d     = memwrite_in;
            addr_d   = addr_in[31:2];
            off_d    = addr_in[1:0];
            dmtype_d = dmtype_in;
            cnt_d    = 8'd0;
            state_d  = StBusy;
            if (!memwrite_in) begin
              be_d    = 4'hF;
              wdata_d = store_data_in;
            end else if (in_byte) begin
              be_d    = 4'b0001 << addr_in[1:0];
              wdata_d = {4{store_data_in[7:0]}};
            end else if (in_half) begin
              be_d    = addr_in[1] ? 4'hC : 4'h3;
              wdata_d = {2{store_data_in[15:0]}};
            end else begin
              be_d    = 4'hF;
              wdata_d = store_data_in;
            end
          end
        end
      end
      StBusy: begin
        stall = 1'b1;
        if (bus_ack) begin
          if (!we_q) load_data_d = load_ext;
          state_d = StDone;
        end else if (timeout) begin
          load_data_d = 32'h0;
          bus_err_d   = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= 30'h0;
      off_q       <= 2'b00;
      dmtype_q    <= 3'b000;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      cnt_q       <= 8'h0;
      load_data_q <= 32'h0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      dmtype_q    <= dmtype_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
      badaddr_q  <= 32'h0;
    end else begin
      misalign_q <= misalign_d;
      badaddr_q  <= badaddr_d;
    end
  end

  assign misalign_out = misalign_q;
  assign badaddr_out  = badaddr_q;
`endif

  // Gated by rst so an abandoned access drops the stall together with the request.
  assign stall_out     = stall & ~rst;
  assign bus_req       = (state_q == StBusy);
  assign bus_we        = we_q;
  assign bus_addr      = {addr_q, 2'b00};
  assign bus_be        = be_q;
  assign bus_wdata     = wdata_q;
  assign load_data_out = load_data_q;
  assign bus_err_out   = bus_err_q;

endmodule
